// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, memory-stage FSM state and writeback bundle for the RV32I pipe.
package pipe_pkg;
   localparam int XLEN = 32;
   localparam int REG_W = 5;
   typedef enum logic {IDLE, BUSY} mem_state_t;
   typedef struct packed {
      logic             regwrite;
      logic [REG_W-1:0] rd;
      logic [XLEN-1:0]  val;
   } wb_t;
   localparam wb_t WB_NOP = '{regwrite: 1'b0, rd: '0, val: '0};
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: word-wide req/ack data-memory port between mem_stage (master) and memory (slave).
interface mem_stage_if;
   import pipe_pkg::*;
   logic            dmem_req;
   logic            dmem_we;
   logic            dmem_ack;
   logic [XLEN-1:0] dmem_addr;
   logic [XLEN-1:0] dmem_wdata;
   logic [XLEN-1:0] dmem_rdata;
   modport master(output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_ack, dmem_rdata);
   modport slave(input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_ack, dmem_rdata);
endinterface

// File: rtl/mem_stage_fsm.sv
// dmem_if_fsm: IDLE/BUSY req/ack sequencer holding address, data and destination rd until ack.
module dmem_if_fsm
   import pipe_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_load_in,
   input  logic [REG_W-1:0] rd_in,
   input  logic [XLEN-1:0]  addr_in,
   input  logic [XLEN-1:0]  wdata_in,
   mem_stage_if.master      dmem,
   output logic             busy,
   output logic             done,
   output logic             done_load,
   output logic [REG_W-1:0] rd
);
   mem_state_t state;
   logic       is_load;
   assign busy = state == BUSY;
   assign done = busy & dmem.dmem_ack;
   assign done_load = done & is_load;
   assign dmem.dmem_req = busy;
   assign dmem.dmem_we = busy & ~is_load;
   // an ack seen while IDLE belongs to an access killed by reset and is dropped
   always_ff @(posedge clk)
      if (!rst) begin
         state <= IDLE;
         is_load <= 1'b0;
         rd <= '0;
         dmem.dmem_addr <= '0;
         dmem.dmem_wdata <= '0;
      end else if (start) begin
         state <= BUSY;
         is_load <= is_load_in;
         rd <= rd_in;
         dmem.dmem_addr <= addr_in;
         dmem.dmem_wdata <= wdata_in;
      end else if (done)
         state <= IDLE;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory stage - dmem access with stall, branch/jump redirect, forwarding, wb register.
// Define MEM_STAGE_PERF_EN to add saturating load/store/stall performance counters.
module mem_stage
   import pipe_pkg::*;
`ifdef MEM_STAGE_PERF_EN
#(
   parameter int PERF_W = 32
)
`endif
(
   input  logic             clk,
   input  logic             rst,
   input  logic             regwrite,
   input  logic             loadF,
   input  logic             storeF,
   input  logic             branchF,
   input  logic             jalF,
   input  logic             jalrF,
   input  logic [XLEN-1:0]  target,
   input  logic [XLEN-1:0]  result,
   input  logic [XLEN-1:0]  store_data,
   input  logic             branch_cond,
   input  logic [REG_W-1:0] regDF,
   mem_stage_if.master      dmem,
   output logic             stall,
   output logic [XLEN-1:0]  stall_val,
   output logic [REG_W-1:0] regD_stall,
   output logic             branch_flush,
   output logic             jal_flush,
   output logic [XLEN-1:0]  redirect_pc,
   output logic [REG_W-1:0] regD_mem,
   output logic [XLEN-1:0]  regD_val_mem,
   output logic             regwrite_mem,
   output logic             wb_regwrite,
   output logic [REG_W-1:0] wb_regD,
   output logic [XLEN-1:0]  wb_val
`ifdef MEM_STAGE_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_ld_cnt,
   output logic [PERF_W-1:0] perf_st_cnt,
   output logic [PERF_W-1:0] perf_stall_cnt
`endif
);
   logic             issue, busy, done, done_load;
   logic [REG_W-1:0] ld_rd;
   wb_t              wb_d, wb_q;
   assign issue = ~busy & (loadF | storeF);
   assign stall = issue | busy;
   assign branch_flush = ~busy & branchF & branch_cond;
   assign jal_flush = ~busy & (jalF | jalrF);
   assign redirect_pc = (branch_flush | jal_flush) ? target : '0;
   assign regD_mem = regDF;
   assign regD_val_mem = result;
   assign regwrite_mem = regwrite & ~loadF & ~storeF & (regDF != '0) & ~busy;
   dmem_if_fsm u_fsm (
      .clk        (clk),
      .rst        (rst),
      .start      (issue),
      .is_load_in (loadF),
      .rd_in      (regDF),
      .addr_in    ({result[XLEN-1:2], 2'b00}),
      .wdata_in   (store_data),
      .dmem       (dmem),
      .busy       (busy),
      .done       (done),
      .done_load  (done_load),
      .rd         (ld_rd)
   );
   // loads retire from memory; issue/wait/store-ack cycles retire nothing
   always_comb
      wb_d = done_load ? '{regwrite: ld_rd != '0, rd: ld_rd, val: dmem.dmem_rdata} :
             stall     ? WB_NOP : '{regwrite: regwrite, rd: regDF, val: result};
   always_ff @(posedge clk)
      if (!rst) begin
         wb_q <= WB_NOP;
         stall_val <= '0;
         regD_stall <= '0;
      end else begin
         wb_q <= wb_d;
         if (done) regD_stall <= done_load ? ld_rd : '0;
         if (done_load) stall_val <= dmem.dmem_rdata;
      end
   assign wb_regwrite = wb_q.regwrite;
   assign wb_regD = wb_q.rd;
   assign wb_val = wb_q.val;
`ifdef MEM_STAGE_PERF_EN
   always_ff @(posedge clk)
      if (!rst) begin
         perf_ld_cnt <= '0;
         perf_st_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (done_load && perf_ld_cnt != '1) perf_ld_cnt <= perf_ld_cnt + 1'b1;
         if (done && !done_load && perf_st_cnt != '1) perf_st_cnt <= perf_st_cnt + 1'b1;
         if (stall && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 1'b1;
      end
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table for the IDLE paths plus hand sequences for memory accesses and reset.
module tb_mem_stage;
   logic        clk = 1'b0, rst = 1'b0;
   logic        regwrite = 0, loadF = 0, storeF = 0, branchF = 0, jalF = 0, jalrF = 0, branch_cond = 0;
   logic [31:0] target = 0, result = 0, store_data = 0;
   logic [4:0]  regDF = 0;
   logic        stall, branch_flush, jal_flush, regwrite_mem, wb_regwrite;
   logic [31:0] stall_val, redirect_pc, regD_val_mem, wb_val;
   logic [4:0]  regD_stall, regD_mem, wb_regD;
   int          checks = 0, errors = 0;
   mem_stage_if dmem();
   mem_stage dut (
      .clk(clk), .rst(rst), .regwrite(regwrite), .loadF(loadF), .storeF(storeF),
      .branchF(branchF), .jalF(jalF), .jalrF(jalrF), .target(target), .result(result),
      .store_data(store_data), .branch_cond(branch_cond), .regDF(regDF), .dmem(dmem),
      .stall(stall), .stall_val(stall_val), .regD_stall(regD_stall),
      .branch_flush(branch_flush), .jal_flush(jal_flush), .redirect_pc(redirect_pc),
      .regD_mem(regD_mem), .regD_val_mem(regD_val_mem), .regwrite_mem(regwrite_mem),
      .wb_regwrite(wb_regwrite), .wb_regD(wb_regD), .wb_val(wb_val)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic        br, bc, jal, jalr, rw;
      logic [4:0]  rd;
      logic [31:0] res, tgt;
      logic        e_bf, e_jf;
      logic [31:0] e_pc;
      logic        e_rwm, e_wbrw;
      logic [4:0]  e_wbrd;
      logic [31:0] e_wbval;
   } vec_t;
   vec_t vecs[7];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic access(input logic ld, input logic st, input logic [31:0] res, input logic [31:0] sd,
                         input logic [4:0] rd, input int waits, input logic [31:0] rdata);
      logic [31:0] ea;
      ea = {res[31:2], 2'b00};
      loadF = ld; storeF = st; result = res; store_data = sd; regDF = rd;
      #1;
      chk("issue_stall", stall, 1);
      chk("issue_req", dmem.dmem_req, 0);
      tick();
      loadF = 0; storeF = 0; result = 0; store_data = 0; regDF = 0;
      for (int i = 0; i <= waits; i++) begin
         if (i == 0) begin branchF = 1; branch_cond = 1; jalF = 1; regwrite = 1; regDF = 3; target = 32'hF0; end
         if (i == waits) begin dmem.dmem_ack = 1; dmem.dmem_rdata = rdata; end
         #1;
         chk("busy_req", dmem.dmem_req, 1);
         chk("busy_we", dmem.dmem_we, st & ~ld);
         chk("busy_addr", dmem.dmem_addr, ea);
         chk("busy_wdata", dmem.dmem_wdata, sd);
         chk("busy_stall", stall, 1);
         chk("busy_wb", wb_regwrite, 0);
         chk("busy_flush", {branch_flush, jal_flush, regwrite_mem}, 0);
         chk("busy_pc", redirect_pc, 0);
         branchF = 0; branch_cond = 0; jalF = 0; regwrite = 0; regDF = 0; target = 0;
         tick();
         dmem.dmem_ack = 0; dmem.dmem_rdata = 0;
      end
      #1;
      chk("done_stall", stall, 0);
      chk("done_req", dmem.dmem_req, 0);
   endtask
   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end
   initial begin
      dmem.dmem_ack = 0; dmem.dmem_rdata = 0;
      vecs[0] = '{1, 1, 0, 0, 0, 5'd0, 32'h0,    32'h80,  1, 0, 32'h80,  0, 0, 5'd0, 32'h0};
      vecs[1] = '{1, 0, 0, 0, 0, 5'd0, 32'h0,    32'h80,  0, 0, 32'h0,   0, 0, 5'd0, 32'h0};
      vecs[2] = '{0, 0, 0, 1, 1, 5'd1, 32'h1004, 32'h40,  0, 1, 32'h40,  1, 1, 5'd1, 32'h1004};
      vecs[3] = '{0, 0, 1, 0, 1, 5'd2, 32'h8,    32'h400, 0, 1, 32'h400, 1, 1, 5'd2, 32'h8};
      vecs[4] = '{0, 0, 0, 0, 1, 5'd7, 32'h1234, 32'h0,   0, 0, 32'h0,   1, 1, 5'd7, 32'h1234};
      vecs[5] = '{0, 0, 0, 0, 1, 5'd0, 32'h55,   32'h0,   0, 0, 32'h0,   0, 1, 5'd0, 32'h55};
      vecs[6] = '{0, 0, 0, 0, 0, 5'd9, 32'hABCD, 32'h20,  0, 0, 32'h0,   0, 0, 5'd9, 32'hABCD};
      for (int i = 0; i < 2; i++) begin
         dmem.dmem_ack = ~dmem.dmem_ack;
         dmem.dmem_rdata = 32'hFFFF_FFFF;
         tick();
      end
      chk("rst_req", {dmem.dmem_req, dmem.dmem_we}, 0);
      chk("rst_addr", dmem.dmem_addr, 0);
      chk("rst_wdata", dmem.dmem_wdata, 0);
      chk("rst_stall", stall, 0);
      chk("rst_stall_val", stall_val, 0);
      chk("rst_regD_stall", regD_stall, 0);
      chk("rst_wb", {wb_regwrite, wb_regD}, 0);
      chk("rst_wb_val", wb_val, 0);
      chk("rst_flush", {branch_flush, jal_flush, regwrite_mem}, 0);
      dmem.dmem_ack = 0; dmem.dmem_rdata = 0;
      rst = 1;
      tick();
      chk("post_rst_stall", stall, 0);
      for (int i = 0; i < 7; i++) begin
         branchF = vecs[i].br; branch_cond = vecs[i].bc; jalF = vecs[i].jal; jalrF = vecs[i].jalr;
         regwrite = vecs[i].rw; regDF = vecs[i].rd; result = vecs[i].res; target = vecs[i].tgt;
         #1;
         chk($sformatf("v%0d_bflush", i), branch_flush, vecs[i].e_bf);
         chk($sformatf("v%0d_jflush", i), jal_flush, vecs[i].e_jf);
         chk($sformatf("v%0d_pc", i), redirect_pc, vecs[i].e_pc);
         chk($sformatf("v%0d_rwm", i), regwrite_mem, vecs[i].e_rwm);
         chk($sformatf("v%0d_fwd_rd", i), regD_mem, vecs[i].rd);
         chk($sformatf("v%0d_fwd_val", i), regD_val_mem, vecs[i].res);
         chk($sformatf("v%0d_stall", i), stall, 0);
         tick();
         chk($sformatf("v%0d_wb_rw", i), wb_regwrite, vecs[i].e_wbrw);
         chk($sformatf("v%0d_wb_rd", i), wb_regD, vecs[i].e_wbrd);
         chk($sformatf("v%0d_wb_val", i), wb_val, vecs[i].e_wbval);
      end
      branchF = 0; branch_cond = 0; jalF = 0; jalrF = 0; regwrite = 0; regDF = 0; result = 0; target = 0;
      access(1, 0, 32'h104, 32'h0, 5'd5, 2, 32'hDEADBEEF);
      chk("ld_stall_val", stall_val, 32'hDEADBEEF);
      chk("ld_regD_stall", regD_stall, 5);
      chk("ld_wb", {wb_regwrite, wb_regD}, {1'b1, 5'd5});
      chk("ld_wb_val", wb_val, 32'hDEADBEEF);
      tick();
      chk("ld_hold_val", stall_val, 32'hDEADBEEF);
      chk("ld_nop_wb", wb_regwrite, 0);
      access(0, 1, 32'h203, 32'h55, 5'd9, 0, 32'h0);
      chk("st_wb", wb_regwrite, 0);
      chk("st_regD_stall", regD_stall, 0);
      chk("st_stall_val", stall_val, 32'hDEADBEEF);
      access(1, 1, 32'h8, 32'hAA, 5'd4, 1, 32'h77);
      chk("both_stall_val", stall_val, 32'h77);
      chk("both_regD_stall", regD_stall, 4);
      chk("both_wb", {wb_regwrite, wb_regD}, {1'b1, 5'd4});
      chk("both_wb_val", wb_val, 32'h77);
      access(1, 0, 32'h10, 32'h0, 5'd0, 0, 32'h123);
      chk("x0_wb", wb_regwrite, 0);
      chk("x0_regD_stall", regD_stall, 0);
      chk("x0_stall_val", stall_val, 32'h123);
      loadF = 1; result = 32'h300; regDF = 6;
      tick();
      loadF = 0; result = 0; regDF = 0;
      #1;
      chk("mid_busy_req", dmem.dmem_req, 1);
      rst = 0;
      tick();
      chk("mid_rst_req", dmem.dmem_req, 0);
      chk("mid_rst_stall_val", stall_val, 0);
      rst = 1;
      dmem.dmem_ack = 1; dmem.dmem_rdata = 32'h99;
      tick();
      dmem.dmem_ack = 0; dmem.dmem_rdata = 0;
      chk("late_ack_req", dmem.dmem_req, 0);
      chk("late_ack_stall", stall, 0);
      chk("late_ack_stall_val", stall_val, 0);
      chk("late_ack_regD_stall", regD_stall, 0);
      chk("late_ack_wb", wb_regwrite, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
